// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter for the shared 16-bit write-back bus.
// Registered one-hot grant and mux selects. Supports locked holds and a watchdog release.
module wb_bus_arbiter #(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [3:0] Req,
   input  logic       Ack,
   input  logic       Lock,
   output logic [3:0] Grant,
   output logic       Sel1,
   output logic       Sel0,
   output logic       Busy,
   output logic       Timeout
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
   localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

   state_t      state_q, state_n;
   logic [1:0]  ptr_q, ptr_n;
   logic [3:0]  hold_q, hold_n;
   logic [4:0]  wait_q, wait_n;
   logic [3:0]  grant_n;
   logic [1:0]  sel_n;
   logic        busy_n, timeout_n;
   logic [1:0]  owner;
   logic        release_bus;
   logic [2:0]  idle_pick, rel_pick;

   // Returns {found, index}: first requester at or after p, wrapping mod 4.
   function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] p);
      logic       found;
      logic [1:0] idx, cand;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         cand = p + 2'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   assign owner     = {Sel1, Sel0};
   assign idle_pick = pick(Req, ptr_q);
   assign rel_pick  = pick(Req, owner + 2'd1);

   always_comb begin
      state_n     = state_q;
      ptr_n       = ptr_q;
      hold_n      = hold_q;
      wait_n      = wait_q;
      grant_n     = Grant;
      sel_n       = owner;
      timeout_n   = 1'b0;
      release_bus = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (idle_pick[2]) begin
               grant_n = 4'b0001 << idle_pick[1:0];
               sel_n   = idle_pick[1:0];
               hold_n  = '0;
               wait_n  = '0;
               state_n = S_GRANT;
            end
         end
         S_GRANT: begin
            if (Ack) begin
               if (Lock && Req[owner] && (hold_q < HOLD_LAST)) begin
                  hold_n = hold_q + 4'd1;
                  wait_n = '0;
               end else begin
                  release_bus = 1'b1;
               end
            end else if (!Req[owner]) begin
               release_bus = 1'b1;
            end else if (wait_q == WAIT_LAST) begin
               release_bus = 1'b1;
               timeout_n   = 1'b1;
            end else begin
               wait_n = wait_q + 5'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase

      // Release re-arbitrates on the same edge from the slot after the old owner.
      if (release_bus) begin
         ptr_n  = owner + 2'd1;
         hold_n = '0;
         wait_n = '0;
         if (rel_pick[2]) begin
            grant_n = 4'b0001 << rel_pick[1:0];
            sel_n   = rel_pick[1:0];
            state_n = S_GRANT;
         end else begin
            grant_n = '0;
            state_n = S_IDLE;
         end
      end

      busy_n = (grant_n != 4'b0000);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         hold_q  <= '0;
         wait_q  <= '0;
         Grant   <= '0;
         Sel1    <= 1'b0;
         Sel0    <= 1'b0;
         Busy    <= 1'b0;
         Timeout <= 1'b0;
      end else begin
         state_q <= state_n;
         ptr_q   <= ptr_n;
         hold_q  <= hold_n;
         wait_q  <= wait_n;
         Grant   <= grant_n;
         Sel1    <= sel_n[1];
         Sel0    <= sel_n[0];
         Busy    <= busy_n;
         Timeout <= timeout_n;
      end
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench for wb_bus_arbiter: stimulus queues expected registered outputs,
// a monitor pops and compares one entry after each rising edge.
module tb_wb_bus_arbiter;

   logic       Clk;
   logic       Reset;
   logic [3:0] Req;
   logic       Ack;
   logic       Lock;
   logic [3:0] Grant;
   logic       Sel1;
   logic       Sel0;
   logic       Busy;
   logic       Timeout;

   int checks = 0;
   int errors = 0;
   int vec    = 0;

   typedef struct {
      int         tag;
      logic [3:0] g;
      logic [1:0] s;
      logic       b;
      logic       t;
   } exp_t;

   exp_t q[$];

   wb_bus_arbiter #(.MAX_HOLD(4), .TIMEOUT(16)) dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .Ack(Ack), .Lock(Lock),
      .Grant(Grant), .Sel1(Sel1), .Sel0(Sel0), .Busy(Busy), .Timeout(Timeout)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (Grant !== e.g || {Sel1, Sel0} !== e.s || Busy !== e.b || Timeout !== e.t) begin
               errors++;
               $display("FAIL vec%0d got grant=%b sel=%b busy=%b to=%b want grant=%b sel=%b busy=%b to=%b",
                        e.tag, Grant, {Sel1, Sel0}, Busy, Timeout, e.g, e.s, e.b, e.t);
            end
         end
      end
   end

   task automatic step(input logic [3:0] r, input logic a, input logic l,
                       input logic [3:0] g, input logic [1:0] s, input logic b, input logic t);
      exp_t e;
      @(negedge Clk);
      Req  = r;
      Ack  = a;
      Lock = l;
      e.tag = vec; e.g = g; e.s = s; e.b = b; e.t = t;
      q.push_back(e);
      vec++;
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (Grant !== 4'b0000 || Sel1 !== 1'b0 || Sel0 !== 1'b0 || Busy !== 1'b0 || Timeout !== 1'b0) begin
         errors++;
         $display("FAIL %s got grant=%b sel=%b busy=%b to=%b want all zero",
                  name, Grant, {Sel1, Sel0}, Busy, Timeout);
      end
   endtask

   initial begin
      Reset = 1'b1;
      Req   = '0;
      Ack   = 1'b0;
      Lock  = 1'b0;
      #1;
      check_reset_outputs("reset_state");
      #11 Reset = 1'b0;

      // Single requester 2, then release to idle (Ptr becomes 3); Ack in idle ignored
      step(4'b0100, 0, 0, 4'b0100, 2'd2, 1, 0);
      step(4'b0000, 1, 0, 4'b0000, 2'd2, 0, 0);
      step(4'b0000, 1, 0, 4'b0000, 2'd2, 0, 0);

      // All request: starts at Ptr=3, then rotates with no idle bubble
      step(4'b1111, 0, 0, 4'b1000, 2'd3, 1, 0);
      step(4'b1111, 1, 0, 4'b0001, 2'd0, 1, 0);
      step(4'b1111, 1, 0, 4'b0010, 2'd1, 1, 0);
      step(4'b1111, 1, 0, 4'b0100, 2'd2, 1, 0);
      step(4'b1111, 1, 0, 4'b1000, 2'd3, 1, 0);
      step(4'b1111, 1, 0, 4'b0001, 2'd0, 1, 0);

      // Locked hold by owner 0: four Acks, then owner 1
      step(4'b0011, 1, 1, 4'b0001, 2'd0, 1, 0);
      step(4'b0011, 1, 1, 4'b0001, 2'd0, 1, 0);
      step(4'b0011, 1, 1, 4'b0001, 2'd0, 1, 0);
      step(4'b0011, 1, 1, 4'b0010, 2'd1, 1, 0);
      step(4'b0000, 1, 0, 4'b0000, 2'd1, 0, 0);

      // Watchdog: sole requester 0, Ack never comes
      step(4'b0001, 0, 0, 4'b0001, 2'd0, 1, 0);
      for (int n = 0; n < 2; n++) begin
         for (int i = 1; i <= 15; i++) step(4'b0001, 0, 0, 4'b0001, 2'd0, 1, 0);
         step(4'b0001, 0, 0, 4'b0001, 2'd0, 1, 1);
      end
      step(4'b0001, 0, 0, 4'b0001, 2'd0, 1, 0);

      // Owner 0 releases to 2; owner 2 drops Req with 1010 present
      step(4'b0100, 1, 0, 4'b0100, 2'd2, 1, 0);
      step(4'b1010, 0, 0, 4'b1000, 2'd3, 1, 0);
      step(4'b1000, 0, 0, 4'b1000, 2'd3, 1, 0);

      // Asynchronous reset between edges
      @(negedge Clk);
      #2;
      Reset = 1'b1;
      Req   = '0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge Clk);
      Reset = 1'b0;
      step(4'b1000, 0, 0, 4'b1000, 2'd3, 1, 0);
      step(4'b0000, 1, 0, 4'b0000, 2'd3, 0, 0);

      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge Clk);
      #2;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got pending=%0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
